// File: rtl/rv32_bus_pkg.sv
// Shared types for the rv32 instruction/data bus arbiter.
package rv32_bus_pkg;

    // Which requester owns (or is granted) the shared memory port.
    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_t;

    // One cycle's worth of shared-bus command, as driven towards the fabric.
    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic        write;
        logic [3:0]  mask;
        logic [31:0] wvalue;
    } bus_cmd_t;

    // Idle bus: every strobe low, address and data zero.
    localparam bus_cmd_t BUS_CMD_IDLE = '{addr: 32'h0, read: 1'b0, write: 1'b0,
                                          mask: 4'h0, wvalue: 32'h0};

    // True when the given owner value refers to an actual requester.
    function automatic logic owner_active(input owner_t owner);
        return (owner != OWNER_NONE);
    endfunction

endpackage : rv32_bus_pkg

// File: rtl/rv32_bus_priority.sv
// Combinational winner selection for a fresh arbitration round.
// Data wins a contested round unless its streak has hit the limit, in which
// case fetch gets exactly this one round.
module rv32_bus_priority
    import rv32_bus_pkg::*;
(
    input  logic   instr_req_i,
    input  logic   data_req_i,
    input  logic   streak_max_i,
    output owner_t winner_o
);

    // Pick the winner from the live requests and the starvation flag.
    always_comb begin
        winner_o = OWNER_NONE;
        if (instr_req_i && data_req_i) begin
            winner_o = streak_max_i ? OWNER_INSTR : OWNER_DATA;
        end else if (data_req_i) begin
            winner_o = OWNER_DATA;
        end else if (instr_req_i) begin
            winner_o = OWNER_INSTR;
        end
    end

endmodule : rv32_bus_priority

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory port between the fetch (instruction) bus and the
// mem-stage (data) bus. Ownership is locked from grant until mem_ready_in,
// data normally wins contested rounds, and a streak counter guarantees that
// fetch gets the bus after MAX_DATA_STREAK consecutive contested data wins.
//
// Handshake: a requester holds its request (instr_read_in, or
// data_read_in/data_write_in) with stable address/data until it sees its
// *_ready_out high in the same cycle; the transaction completes in exactly
// that cycle. The bus command is a pure combinational function of the
// current grant, so a one-cycle memory completes with zero added latency.
// Dropping a request before ready abandons the transaction and the port is
// re-arbitrated in that same cycle.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,

    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,

    output logic [31:0] mem_address_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [3:0]  mem_write_mask_out,
    output logic [31:0] mem_write_value_out,
    input  logic [31:0] mem_read_value_in,
    input  logic        mem_ready_in,

    output logic        grant_instr_out,
    output logic        grant_data_out
);

    localparam int unsigned         STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    owner_t              owner_q;
    owner_t              owner_d;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    logic     instr_req;
    logic     data_req;
    logic     owner_held;
    logic     streak_max;
    owner_t   arb_winner;
    owner_t   grant;
    bus_cmd_t bus_cmd;

    assign instr_req  = instr_read_in;
    assign data_req   = data_read_in | data_write_in;
    assign streak_max = (streak_q == STREAK_MAX);

    // Fresh-round winner; only consulted when no locked owner is still requesting.
    rv32_bus_priority u_priority (
        .instr_req_i  (instr_req),
        .data_req_i   (data_req),
        .streak_max_i (streak_max),
        .winner_o     (arb_winner)
    );

    // Resolve this cycle's grant: a locked owner keeps the bus while it still
    // requests; otherwise re-arbitrate. Reset forces an idle grant so every
    // bus-facing output reads zero while reset is held.
    always_comb begin
        owner_held = 1'b0;
        grant      = OWNER_NONE;
        if (!reset) begin
            owner_held = ((owner_q == OWNER_INSTR) && instr_req) ||
                         ((owner_q == OWNER_DATA)  && data_req);
            grant      = owner_held ? owner_q : arb_winner;
        end
    end

    // Next owner and streak: release on completion, lock while the slave stalls.
    always_comb begin
        owner_d  = OWNER_NONE;
        streak_d = streak_q;
        if (reset) begin
            owner_d  = OWNER_NONE;
            streak_d = '0;
        end else if (owner_active(grant)) begin
            if (mem_ready_in) begin
                owner_d = OWNER_NONE;
                if (grant == OWNER_DATA && instr_req) begin
                    // Fetch was kept waiting by this data transaction.
                    streak_d = streak_max ? streak_q : streak_q + STREAK_W'(1);
                end else begin
                    streak_d = '0;
                end
            end else begin
                owner_d = grant;
            end
        end
    end

    // Owner and streak registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWNER_NONE;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // Shared bus command mux; fetch is always a plain full-word read.
    always_comb begin
        bus_cmd = BUS_CMD_IDLE;
        case (grant)
            OWNER_INSTR: begin
                bus_cmd.addr = instr_address_in;
                bus_cmd.read = 1'b1;
            end
            OWNER_DATA: begin
                bus_cmd.addr   = data_address_in;
                bus_cmd.read   = data_read_in;
                bus_cmd.write  = data_write_in;
                bus_cmd.mask   = data_write_mask_in;
                bus_cmd.wvalue = data_write_value_in;
            end
            default: bus_cmd = BUS_CMD_IDLE;
        endcase
    end

    assign mem_address_out     = bus_cmd.addr;
    assign mem_read_out        = bus_cmd.read;
    assign mem_write_out       = bus_cmd.write;
    assign mem_write_mask_out  = bus_cmd.mask;
    assign mem_write_value_out = bus_cmd.wvalue;

    // Read data is broadcast; only the granted side sees ready.
    assign instr_read_value_out = mem_read_value_in;
    assign data_read_value_out  = mem_read_value_in;
    assign instr_ready_out      = mem_ready_in && (grant == OWNER_INSTR);
    assign data_ready_out       = mem_ready_in && (grant == OWNER_DATA);

    assign grant_instr_out = (grant == OWNER_INSTR);
    assign grant_data_out  = (grant == OWNER_DATA);

endmodule : rv32_bus_arbiter
